// File: rtl/wb_queue_pkg.sv
// Shared widths and entry payload for the write-back queue.
package wb_queue_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_match.sv
// Youngest-match bypass search over the occupied queue entries.
module wb_match
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  wb_entry_t [DEPTH-1:0]   entries,
  input  logic [PTR_W-1:0]        head,
  input  logic [CNT_W-1:0]        count,
  input  logic [REG_ADDR_W-1:0]   raddr,
  output logic                    hit_c,
  output logic [DATA_W-1:0]       fwd_c
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_c = 1'b0;
    fwd_c = '0;
    idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (raddr != '0) && (entries[idx].addr == raddr)) begin
        hit_c = 1'b1;
        fwd_c = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: arbitrates ALU/load results into a FIFO that drains
// one entry per cycle into the register file, with pending-write bypass.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        hit1,
  output logic        hit2,
  output logic [31:0] fwd1,
  output logic [31:0] fwd2,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t             in_entry;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      cnt;
  logic                  push;
  logic                  store;
  logic                  pop;

  assign full      = (cnt == CNT_W'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  // Load results win arbitration; writes to x0 are accepted and dropped.
  always_comb begin
    in_entry = '0;
    if (mem_valid) begin
      in_entry.addr = mem_addr;
      in_entry.data = mem_data;
    end else begin
      in_entry.addr = alu_addr;
      in_entry.data = alu_data;
    end
  end

  assign push  = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign store = push && (in_entry.addr != '0);

  assign rf_we    = !empty;
  assign pop      = rf_we;
  assign rf_waddr = empty ? '0 : entries[head].addr;
  assign rf_wdata = empty ? '0 : entries[head].data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (store) tail <= tail + PTR_W'(1);
      if (pop)   head <= head + PTR_W'(1);
      cnt <= cnt + CNT_W'(store) - CNT_W'(pop);
    end
  end

  // Payload storage carries no reset; occupancy is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (store) entries[tail] <= in_entry;
  end

  wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match1 (
    .entries (entries),
    .head    (head),
    .count   (cnt),
    .raddr   (raddr1),
    .hit_c   (hit1),
    .fwd_c   (fwd1)
  );

  wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match2 (
    .entries (entries),
    .head    (head),
    .count   (cnt),
    .raddr   (raddr2),
    .hit_c   (hit2),
    .fwd_c   (fwd2)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with a scoreboard model of the queue contents.
module tb_wb_queue;
  import wb_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr1, raddr2;
  logic        hit1, hit2;
  logic [31:0] fwd1, fwd2;
  logic        full, empty;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  bit hold   = 1'b0;
  wb_entry_t sb[$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input logic [4:0] ra, output logic h, output logic [31:0] f);
    h = 1'b0;
    f = '0;
    if (ra != 5'd0)
      foreach (sb[i])
        if (sb[i].addr == ra) begin
          h = 1'b1;
          f = sb[i].data;
        end
  endfunction

  task automatic chk_lookup(input string when);
    logic h;
    logic [31:0] f;
    lookup(raddr1, h, f);
    chk({when, " hit1"}, 32'(hit1), 32'(h));
    chk({when, " fwd1"}, fwd1, f);
    lookup(raddr2, h, f);
    chk({when, " hit2"}, 32'(hit2), 32'(h));
    chk({when, " fwd2"}, fwd2, f);
  endtask

  task automatic set_hold(input bit b);
    hold = b;
    if (b) force dut.pop = 1'b0;
    else   release dut.pop;
  endtask

  // One clock: check handshake/lookup before the edge, update model, check state after.
  task automatic step();
    bit full_m, pop_m, acc_mem, acc_alu;
    wb_entry_t e;
    #1;
    full_m  = (sb.size() == DEPTH);
    pop_m   = (sb.size() != 0) && !hold;
    acc_mem = mem_valid && !full_m;
    acc_alu = alu_valid && !full_m && !mem_valid;
    chk("mem_ready", 32'(mem_ready), 32'(!full_m));
    chk("alu_ready", 32'(alu_ready), 32'(!full_m && !mem_valid));
    chk_lookup("pre");
    @(posedge clk);
    #1;
    if (pop_m) void'(sb.pop_front());
    if (acc_mem && mem_addr != 5'd0) begin
      e.addr = mem_addr; e.data = mem_data; sb.push_back(e);
    end
    if (acc_alu && alu_addr != 5'd0) begin
      e.addr = alu_addr; e.data = alu_data; sb.push_back(e);
    end
    chk("count", 32'(count), 32'(sb.size()));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("full", 32'(full), 32'(sb.size() == DEPTH));
    chk("rf_we", 32'(rf_we), 32'(sb.size() != 0));
    chk("rf_waddr", 32'(rf_waddr), (sb.size() != 0) ? 32'(sb[0].addr) : 32'd0);
    chk("rf_wdata", rf_wdata, (sb.size() != 0) ? sb[0].data : 32'd0);
    chk_lookup("post");
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_valid = v; alu_addr = a; alu_data = d;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
    mem_valid = v; mem_addr = a; mem_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    #1;
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst rf_we", 32'(rf_we), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst hit1", 32'(hit1), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write then drain
    drive_alu(1'b1, 5'd5, 32'h1111_1111);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    step();

    // Arbitration: mem first, alu next cycle
    drive_mem(1'b1, 5'd3, 32'h0000_000A);
    drive_alu(1'b1, 5'd4, 32'h0000_000B);
    step();
    drive_mem(1'b0, 5'd0, 32'd0);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    step();
    step();

    // Write to x0 is dropped
    drive_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    step();

    // Fill with pops held off; bypass must pick the youngest addr 7
    set_hold(1'b1);
    raddr1 = 5'd7;
    drive_alu(1'b1, 5'd7, 32'h0000_0001);
    step();
    drive_alu(1'b1, 5'd7, 32'h0000_0002);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    chk("bypass young fwd1", fwd1, 32'h0000_0002);
    drive_mem(1'b1, 5'd10, 32'h0000_00AA);
    raddr2 = 5'd10;
    step();
    drive_mem(1'b0, 5'd0, 32'd0);
    drive_alu(1'b1, 5'd11, 32'h0000_00BB);
    step();
    drive_mem(1'b1, 5'd12, 32'h0000_00CC);
    drive_alu(1'b1, 5'd13, 32'h0000_00DD);
    chk("full flag", 32'(full), 32'd1);
    step();
    step();
    drive_mem(1'b0, 5'd0, 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    raddr2 = 5'd0;
    set_hold(1'b0);
    repeat (5) step();

    // Wrapped pointers: refill and drain again
    drive_mem(1'b1, 5'd20, 32'hDEAD_0020);
    step();
    drive_mem(1'b0, 5'd0, 32'd0);
    drive_alu(1'b1, 5'd21, 32'hDEAD_0021);
    raddr2 = 5'd21;
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    repeat (3) step();

    // Asynchronous reset mid-operation with three entries
    set_hold(1'b1);
    drive_alu(1'b1, 5'd12, 32'h0000_0C0C);
    step();
    drive_alu(1'b1, 5'd13, 32'h0000_0D0D);
    step();
    drive_alu(1'b1, 5'd14, 32'h0000_0E0E);
    raddr1 = 5'd13;
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    chk("pre-reset count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rf_we", 32'(rf_we), 32'd0);
    chk("async rst empty", 32'(empty), 32'd1);
    chk("async rst hit1", 32'(hit1), 32'd0);
    chk("async rst count", 32'(count), 32'd0);
    sb.delete();
    set_hold(1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_alu(1'b1, 5'd15, 32'h0000_1234);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
